// File: rtl/axi_zero_init.sv
// AXI4 master that clears a memory region with all-zero INCR write bursts.
// Optional read-back verification is compiled in with AXI_ZERO_INIT_READBACK_EN.
package axi_zero_init_pkg;
  localparam int unsigned AW = 64, DW = 64, IW = 4, UW = 1;
  typedef struct packed {
    logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot;
    logic [3:0] qos; logic [3:0] region; logic [5:0] atop; logic [UW-1:0] user;
  } aw_chan_t;
  typedef struct packed {
    logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; logic [UW-1:0] user;
  } w_chan_t;
  typedef struct packed {
    logic [IW-1:0] id; logic [1:0] resp; logic [UW-1:0] user;
  } b_chan_t;
  typedef struct packed {
    logic [IW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size;
    logic [1:0] burst; logic lock; logic [3:0] cache; logic [2:0] prot;
    logic [3:0] qos; logic [3:0] region; logic [UW-1:0] user;
  } ar_chan_t;
  typedef struct packed {
    logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; logic [UW-1:0] user;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
    ar_chan_t ar; logic ar_valid; logic r_ready;
  } axi_req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_t b;
    logic r_valid; r_chan_t r;
  } axi_resp_t;
endpackage

module axi_zero_init #(
  parameter type axi_req_t  = axi_zero_init_pkg::axi_req_t,
  parameter type axi_resp_t = axi_zero_init_pkg::axi_resp_t,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AxiId     = 0,
  parameter int unsigned MaxBeats  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output axi_req_t             axi_req_o,
  input  axi_resp_t            axi_resp_i
);
  localparam int unsigned Bytes   = DataWidth / 8;
  localparam int unsigned SizeLog = $clog2(Bytes);

  typedef enum logic [2:0] {
    IDLE, AW, W, BRESP, FIN
`ifdef AXI_ZERO_INIT_READBACK_EN
    , AR, R
`endif
  } state_e;

  state_e state_q;
  logic [AddrWidth-1:0] addr_q, rem_q, nxt_addr, nxt_rem, start_addr, start_beats;
  logic [8:0] beats_q, cnt_q;
  logic aw_valid_q, w_valid_q, b_ready_q, r_ready_q, busy_q, done_q, err_q, last_beat;
`ifdef AXI_ZERO_INIT_READBACK_EN
  logic [AddrWidth-1:0] base_q, tot_q;
  logic ar_valid_q;
`endif

  // Burst length limited by remaining beats, MaxBeats and the 4 KiB page end.
  function automatic logic [8:0] calc_beats(input logic [11:0] off, input logic [AddrWidth-1:0] r);
    logic [AddrWidth-1:0] room, n;
    room = AddrWidth'((13'd4096 - {1'b0, off}) >> SizeLog);
    n = AddrWidth'(MaxBeats);
    if (room < n) n = room;
    if (r < n) n = r;
    return n[8:0];
  endfunction

  assign start_addr  = base_addr_i & ~AddrWidth'(Bytes - 1);
  assign start_beats = len_i >> SizeLog;
  assign nxt_addr    = addr_q + (AddrWidth'(beats_q) << SizeLog);
  assign nxt_rem     = rem_q - AddrWidth'(beats_q);
  assign last_beat   = (cnt_q == beats_q - 9'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE; addr_q <= '0; rem_q <= '0; beats_q <= 9'd1; cnt_q <= '0;
      aw_valid_q <= 1'b0; w_valid_q <= 1'b0; b_ready_q <= 1'b0; r_ready_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
`ifdef AXI_ZERO_INIT_READBACK_EN
      base_q <= '0; tot_q <= '0; ar_valid_q <= 1'b0;
`endif
    end else begin
      r_ready_q <= 1'b1;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          err_q <= 1'b0; busy_q <= 1'b1;
          addr_q <= start_addr; rem_q <= start_beats;
`ifdef AXI_ZERO_INIT_READBACK_EN
          base_q <= start_addr; tot_q <= start_beats;
`endif
          if (start_beats != '0) begin
            beats_q <= calc_beats(start_addr[11:0], start_beats);
            aw_valid_q <= 1'b1; state_q <= AW;
          end else state_q <= FIN;
        end
        AW: if (axi_resp_i.aw_ready) begin
          aw_valid_q <= 1'b0; w_valid_q <= 1'b1; cnt_q <= '0; state_q <= W;
        end
        W: if (axi_resp_i.w_ready) begin
          if (last_beat) begin
            w_valid_q <= 1'b0; b_ready_q <= 1'b1; state_q <= BRESP;
          end else cnt_q <= cnt_q + 9'd1;
        end
        BRESP: if (axi_resp_i.b_valid) begin
          b_ready_q <= 1'b0; addr_q <= nxt_addr; rem_q <= nxt_rem;
          if (axi_resp_i.b.resp[1]) begin
            err_q <= 1'b1; state_q <= FIN;
          end else if (nxt_rem != '0) begin
            beats_q <= calc_beats(nxt_addr[11:0], nxt_rem);
            aw_valid_q <= 1'b1; state_q <= AW;
          end else begin
`ifdef AXI_ZERO_INIT_READBACK_EN
            addr_q <= base_q; rem_q <= tot_q;
            beats_q <= calc_beats(base_q[11:0], tot_q);
            ar_valid_q <= 1'b1; state_q <= AR;
`else
            state_q <= FIN;
`endif
          end
        end
`ifdef AXI_ZERO_INIT_READBACK_EN
        AR: if (axi_resp_i.ar_ready) begin
          ar_valid_q <= 1'b0; cnt_q <= '0; state_q <= R;
        end
        // Read errors are recorded but the whole region is still walked.
        R: if (axi_resp_i.r_valid) begin
          if (axi_resp_i.r.data != '0 || axi_resp_i.r.resp[1]) err_q <= 1'b1;
          if (last_beat) begin
            addr_q <= nxt_addr; rem_q <= nxt_rem;
            if (nxt_rem != '0) begin
              beats_q <= calc_beats(nxt_addr[11:0], nxt_rem);
              ar_valid_q <= 1'b1; state_q <= AR;
            end else state_q <= FIN;
          end else cnt_q <= cnt_q + 9'd1;
        end
`endif
        FIN: begin
          busy_q <= 1'b0; done_q <= 1'b1; state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    axi_req_o = '0;
    axi_req_o.aw_valid = aw_valid_q;
    if (aw_valid_q) begin
      axi_req_o.aw.id    = IdWidth'(AxiId);
      axi_req_o.aw.addr  = addr_q;
      axi_req_o.aw.len   = 8'(beats_q - 9'd1);
      axi_req_o.aw.size  = 3'(SizeLog);
      axi_req_o.aw.burst = 2'b01;
    end
    axi_req_o.w_valid = w_valid_q;
    if (w_valid_q) begin
      axi_req_o.w.strb = '1;
      axi_req_o.w.last = last_beat;
    end
    axi_req_o.b_ready = b_ready_q;
    axi_req_o.r_ready = r_ready_q;
`ifdef AXI_ZERO_INIT_READBACK_EN
    axi_req_o.ar_valid = ar_valid_q;
    if (ar_valid_q) begin
      axi_req_o.ar.id    = IdWidth'(AxiId);
      axi_req_o.ar.addr  = addr_q;
      axi_req_o.ar.len   = 8'(beats_q - 9'd1);
      axi_req_o.ar.size  = 3'(SizeLog);
      axi_req_o.ar.burst = 2'b01;
    end
`endif
  end

  logic unused_resp;
  assign unused_resp = ^axi_resp_i;

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o  = err_q;
endmodule

// File: tb/tb_axi_zero_init.sv
// Directed bench for axi_zero_init: a small AXI slave model logs AW/W/B traffic,
// each scenario task checks its own results against hand-computed values.
module tb_axi_zero_init;
  import axi_zero_init_pkg::*;

  logic clk = 1'b0, rst, start, busy, done, err;
  logic [63:0] base_addr, len;
  axi_req_t  req;
  axi_resp_t resp;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  axi_zero_init #(
    .axi_req_t(axi_req_t), .axi_resp_t(axi_resp_t), .AddrWidth(64), .DataWidth(64),
    .IdWidth(4), .AxiId(0), .MaxBeats(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr), .len_i(len),
    .busy_o(busy), .done_o(done), .err_o(err), .axi_req_o(req), .axi_resp_i(resp)
  );

  // Slave model: readies and B are driven at negedge, so a handshake logged here
  // is the one the DUT sees at the following posedge.
  int aw_n = 0, w_n = 0, b_n = 0, done_n = 0, aw_bad = 0, w_bad = 0, unstable = 0;
  int beat_cnt = 0, slverr_idx = -1;
  bit stall_en = 0, b_pend = 0, aw_hold = 0, w_hold = 0;
  logic w_hold_last;
  logic [63:0] hold_addr;
  logic [7:0]  hold_len;
  logic [63:0] aw_addr_log [0:255];
  logic [7:0]  aw_len_log  [0:255];
  logic [2:0]  aw_size_log [0:255];

  always @(negedge clk) begin
    if (rst) begin
      resp = '0; beat_cnt = 0; b_pend = 0; aw_hold = 0; w_hold = 0;
    end else begin
      resp.b_valid = b_pend;
      resp.b.resp  = (b_n == slverr_idx) ? 2'b10 : 2'b00;
      if (resp.b_valid && req.b_ready) begin b_pend = 0; b_n++; end
      if (aw_hold && (!req.aw_valid || req.aw.addr !== hold_addr || req.aw.len !== hold_len)) unstable++;
      resp.aw_ready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      aw_hold = 0;
      if (req.aw_valid && resp.aw_ready) begin
        if (aw_n < 256) begin
          aw_addr_log[aw_n] = req.aw.addr; aw_len_log[aw_n] = req.aw.len; aw_size_log[aw_n] = req.aw.size;
        end
        if (req.aw.burst !== 2'b01 || req.aw.id !== 4'd0 || {req.aw.lock, req.aw.cache, req.aw.prot,
            req.aw.qos, req.aw.region, req.aw.atop, req.aw.user} !== '0) aw_bad++;
        aw_n++;
      end else if (req.aw_valid) begin
        aw_hold = 1; hold_addr = req.aw.addr; hold_len = req.aw.len;
      end
      if (w_hold && (!req.w_valid || req.w.last !== w_hold_last)) unstable++;
      resp.w_ready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      w_hold = 0;
      if (req.w_valid && resp.w_ready) begin
        w_n++; beat_cnt++;
        if (req.w.data !== '0 || req.w.strb !== 8'hFF) w_bad++;
        if (aw_n > 0 && req.w.last !== (beat_cnt == int'(aw_len_log[aw_n-1]) + 1)) w_bad++;
        if (req.w.last) begin b_pend = 1; beat_cnt = 0; end
      end else if (req.w_valid) begin
        w_hold = 1; w_hold_last = req.w.last;
      end
    end
    if (done === 1'b1) done_n++;
  end

  task automatic start_op(input logic [63:0] b, input logic [63:0] l);
    base_addr = b; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    repeat (3) @(posedge clk); #1;
    n_vec++; if ({req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready} !== 5'b0) begin n_err++; $display("FAIL reset_axi got %b want 00000", {req.aw_valid, req.w_valid, req.b_ready, req.ar_valid, req.r_ready}); end
    n_vec++; if ({busy, done, err} !== 3'b0) begin n_err++; $display("FAIL reset_status got %b want 000", {busy, done, err}); end
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_vec++; if (req.r_ready !== 1'b1 || req.ar_valid !== 1'b0) begin n_err++; $display("FAIL idle_read_chan got r_ready=%b ar_valid=%b want 1 0", req.r_ready, req.ar_valid); end
  endtask

  task automatic test_single_burst;
    int a0, w0, d0, ab0, wb0; bit ok;
    a0 = aw_n; w0 = w_n; d0 = done_n; ab0 = aw_bad; wb0 = w_bad;
    start_op(64'h1000, 64'h80);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy); end
    wait_done(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_done got timeout want done"); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL single_err got %b want 0", err); end
    repeat (3) @(posedge clk); #1;
    n_vec++; if (aw_n - a0 !== 1) begin n_err++; $display("FAIL single_aw_count got %0d want 1", aw_n - a0); end
    n_vec++; if (aw_addr_log[a0] !== 64'h1000 || aw_len_log[a0] !== 8'd15 || aw_size_log[a0] !== 3'd3) begin n_err++; $display("FAIL single_aw got addr=%h len=%0d size=%0d want 1000 15 3", aw_addr_log[a0], aw_len_log[a0], aw_size_log[a0]); end
    n_vec++; if (w_n - w0 !== 16) begin n_err++; $display("FAIL single_beats got %0d want 16", w_n - w0); end
    n_vec++; if (done_n - d0 !== 1) begin n_err++; $display("FAIL single_done_pulses got %0d want 1", done_n - d0); end
    n_vec++; if (aw_bad - ab0 !== 0 || w_bad - wb0 !== 0) begin n_err++; $display("FAIL single_fields got aw_bad=%0d w_bad=%0d want 0 0", aw_bad - ab0, w_bad - wb0); end
  endtask

  task automatic test_page_split;
    int a0, w0, wb0; bit ok;
    logic [63:0] exp_addr [3];
    logic [7:0]  exp_len  [3];
    exp_addr = '{64'hFC0, 64'h1000, 64'h1080};
    exp_len  = '{8'd7, 8'd15, 8'd7};
    a0 = aw_n; w0 = w_n; wb0 = w_bad;
    start_op(64'hFC0, 64'h100);
    wait_done(400, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL split_done got timeout want done"); end
    repeat (2) @(posedge clk); #1;
    n_vec++; if (aw_n - a0 !== 3) begin n_err++; $display("FAIL split_aw_count got %0d want 3", aw_n - a0); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (aw_addr_log[a0+i] !== exp_addr[i] || aw_len_log[a0+i] !== exp_len[i]) begin n_err++; $display("FAIL split_aw%0d got addr=%h len=%0d want %h %0d", i, aw_addr_log[a0+i], aw_len_log[a0+i], exp_addr[i], exp_len[i]); end
    end
    n_vec++; if (w_n - w0 !== 32 || w_bad - wb0 !== 0) begin n_err++; $display("FAIL split_beats got %0d bad=%0d want 32 0", w_n - w0, w_bad - wb0); end
  endtask

  task automatic test_slverr;
    int a0, d0; bit ok;
    a0 = aw_n; d0 = done_n; slverr_idx = b_n;
    start_op(64'h2000, 64'h40);
    wait_done(300, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL slverr_done got timeout want done"); end
    n_vec++; if (err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL slverr_status got err=%b busy=%b want 1 0", err, busy); end
    repeat (3) @(posedge clk); #1;
    n_vec++; if (aw_n - a0 !== 1 || done_n - d0 !== 1) begin n_err++; $display("FAIL slverr_counts got aw=%0d done=%0d want 1 1", aw_n - a0, done_n - d0); end
    // Multi-burst region: the error on the first B must stop the remaining seven bursts.
    a0 = aw_n; slverr_idx = b_n;
    start_op(64'h2000, 64'h400);
    wait_done(300, ok);
    repeat (3) @(posedge clk); #1;
    n_vec++; if (!ok || aw_n - a0 !== 1 || err !== 1'b1) begin n_err++; $display("FAIL slverr_abort got done=%0d aw=%0d err=%b want 1 1 1", ok, aw_n - a0, err); end
    slverr_idx = -1;
  endtask

  task automatic test_short_len;
    int a0;
    a0 = aw_n;
    start_op(64'h3000, 64'h5);
    n_vec++; if ({busy, done, err} !== 3'b100) begin n_err++; $display("FAIL short_c1 got busy,done,err=%b want 100", {busy, done, err}); end
    @(posedge clk); #1;
    n_vec++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL short_c2 got busy,done=%b want 01", {busy, done}); end
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL short_c3 got done=%b want 0", done); end
    repeat (2) @(posedge clk); #1;
    n_vec++; if (aw_n - a0 !== 0) begin n_err++; $display("FAIL short_aw got %0d want 0", aw_n - a0); end
  endtask

  task automatic test_stalls;
    int a0, w0, u0, wb0; bit ok;
    a0 = aw_n; w0 = w_n; u0 = unstable; wb0 = w_bad;
    stall_en = 1;
    start_op(64'h0, 64'h400);
    wait_done(4000, ok);
    stall_en = 0;
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_done got timeout want done"); end
    repeat (3) @(posedge clk); #1;
    n_vec++; if (aw_n - a0 !== 8 || w_n - w0 !== 128) begin n_err++; $display("FAIL stall_counts got aw=%0d beats=%0d want 8 128", aw_n - a0, w_n - w0); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (aw_addr_log[a0+i] !== 64'(i) * 64'h80 || aw_len_log[a0+i] !== 8'd15) begin n_err++; $display("FAIL stall_aw%0d got addr=%h len=%0d want %h 15", i, aw_addr_log[a0+i], aw_len_log[a0+i], 64'(i) * 64'h80); end
    end
    n_vec++; if (unstable - u0 !== 0 || w_bad - wb0 !== 0) begin n_err++; $display("FAIL stall_stable got unstable=%0d w_bad=%0d want 0 0", unstable - u0, w_bad - wb0); end
  endtask

  task automatic test_reset_mid;
    int a0; bit hit, ok;
    a0 = aw_n; hit = 0;
    start_op(64'h0, 64'h400);
    for (int i = 0; i < 300; i++) begin
      if (aw_n - a0 >= 2 && req.w_valid === 1'b1) begin hit = 1; break; end
      @(posedge clk); #1;
    end
    n_vec++; if (!hit) begin n_err++; $display("FAIL rstmid_reach got timeout want second burst W"); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({req.aw_valid, req.w_valid, req.b_ready, busy, done} !== 5'b0) begin n_err++; $display("FAIL rstmid_clear got %b want 00000", {req.aw_valid, req.w_valid, req.b_ready, busy, done}); end
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    a0 = aw_n;
    start_op(64'h3000, 64'h80);
    wait_done(300, ok);
    repeat (2) @(posedge clk); #1;
    n_vec++; if (!ok || err !== 1'b0 || aw_n - a0 !== 1 || aw_addr_log[a0] !== 64'h3000) begin n_err++; $display("FAIL rstmid_restart got done=%0d err=%b aw=%0d addr=%h want 1 0 1 3000", ok, err, aw_n - a0, aw_addr_log[a0]); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_page_split();
    test_slverr();
    test_short_len();
    test_stalls();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
